uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side frame buffer placed directly downstream of the UART receiver. It captures each completed frame and its error status, then holds them in a small circular FIFO. The host or bus side drains frames through a valid/ready interface. Overflow is reported through a sticky overrun flag.

Parameters:
DEPTH, 8, number of frame entries; power of two, minimum 2
ADDR_W, 3, log2(DEPTH); pointer width

Ports:
CLK  input  1  system clock; all logic rising-edge
RST  input  1  synchronous active-low reset
P_DATA  input  8  received byte from the receiver
Data_Valid  input  1  one-cycle pulse: good frame on P_DATA
Parity_Error  input  1  one-cycle pulse: frame completed with parity error
Stop_Error  input  1  one-cycle pulse: frame completed with stop error
rd_data  output  8  head-entry byte
rd_par_err  output  1  head-entry parity-error flag
rd_stp_err  output  1  head-entry stop-error flag
rd_valid  output  1  FIFO non-empty; head entry presented
rd_ready  input  1  consumer accepts head entry
fifo_count  output  ADDR_W+1  current occupancy, 0..DEPTH
overrun  output  1  sticky: a frame was dropped because the FIFO was full
clr_ovr  input  1  clears overrun
err_frames  output  8  saturating count of discarded error frames (macro-dependent)

Behaviour:
- Reset (RST=0 at a rising edge) sets the following:
  - wr_ptr=0, rd_ptr=0, fifo_count=0, overrun=0, err_frames=0.
  - All status outputs go low.
  - rd_data, rd_par_err and rd_stp_err read 0.
- Reset mid-stream discards all stored entries; storage contents need not be cleared.
- Write event (wr_evt) = Data_Valid | Parity_Error | Stop_Error, sampled each cycle.
  - Each asserted cycle is exactly one frame; the upstream receiver drives one-cycle pulses.
- Stored entry is 10 bits: {Stop_Error, Parity_Error, P_DATA}, captured on the same edge as wr_evt.
- Read side is show-ahead:
  - rd_valid = (fifo_count != 0).
  - rd_data, rd_par_err and rd_stp_err come combinationally from mem[rd_ptr] when rd_valid=1, and are forced to 0 when rd_valid=0.
- Pop = rd_valid & rd_ready. A pop increments rd_ptr modulo DEPTH at the edge.
- Push = accepted wr_evt. A push writes mem[wr_ptr] and increments wr_ptr modulo DEPTH. Pointer wrap is natural ADDR_W-bit rollover.
- Latency: a frame written at edge N is visible with rd_valid=1 in the cycle after edge N. Write-to-read latency is one cycle.
- fifo_count update per edge:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Full (fifo_count==DEPTH):
  - wr_evt with a pop in the same cycle: accepted; count stays DEPTH.
  - wr_evt without a pop: frame dropped, pointers unchanged, overrun set to 1.
- Empty: rd_ready is ignored; no pointer or count change occurs.
- overrun:
  - Set by a dropped frame; stays set until clr_ovr=1.
  - If clr_ovr and a new drop occur in the same cycle, set wins (overrun=1).
- fifo_count, overrun and err_frames are registered.
- No other state machine: the block is two pointers, an occupancy counter and sticky flags. The implementation is a pure circular buffer.

Optional Feature:
Macro: UART_RX_FIFO_DISCARD_ERR_EN.
- Defined:
  - A wr_evt with Parity_Error or Stop_Error set is never written and does not count as a push.
  - err_frames increments by 1 per such event and saturates at 255.
  - Discarded error frames never set overrun, even when the FIFO is full.
  - rd_par_err and rd_stp_err are always 0.
- Undefined:
  - Error frames are stored like good frames with their flags.
  - err_frames is tied to 0.

Test Plan:
1. Reset, then one Data_Valid pulse with P_DATA=0xA5 -> next cycle rd_valid=1, rd_data=0xA5, fifo_count=1. Pulse rd_ready one cycle -> rd_valid=0, fifo_count=0, rd_data=0.
2. Write 8 frames 0x01..0x08 with rd_ready=0 -> fifo_count=8. Ninth frame 0x09 -> dropped, overrun=1. Drain -> reads 0x01..0x08 in order. clr_ovr -> overrun=0.
3. Fill to 8, then wr_evt(0x55) with rd_ready=1 in the same cycle -> count stays 8, no overrun. Drain -> last entry read is 0x55.
4. Run 20 push/pop pairs with data 0x10..0x23, keeping 1-2 entries resident -> pointers wrap past 7 and read order is preserved.
5. Parity_Error pulse with P_DATA=0x3C:
   - Macro undefined -> entry read with rd_par_err=1, rd_data=0x3C.
   - Macro defined -> rd_valid stays 0, err_frames=1.
   - Macro defined, 300 error pulses -> err_frames=255.
6. Hold RST=0 for one edge with 4 entries stored and overrun=1 -> fifo_count=0, rd_valid=0, overrun=0 immediately after that edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side frame buffer behind the UART receiver.
// Each completed frame ({stop_err, parity_err, byte}) goes into a circular
// FIFO. The FIFO is drained show-ahead through a valid/ready handshake.
// A sticky overrun flag records frames that were dropped while the FIFO was full.
// Optional macro UART_RX_FIFO_DISCARD_ERR_EN: error frames are discarded
// rather than stored, and they are counted in a saturating err_frames counter.
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        P_DATA,
  input  logic              Data_Valid,
  input  logic              Parity_Error,
  input  logic              Stop_Error,
  output logic [7:0]        rd_data,
  output logic              rd_par_err,
  output logic              rd_stp_err,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overrun,
  input  logic              clr_ovr,
  output logic [7:0]        err_frames
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [9:0]        mem [0:DEPTH-1];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovr_q, ovr_d;
  logic              wr_evt, wr_req, full, push, pop, drop;
  logic [9:0]        head;

  assign wr_evt = Data_Valid | Parity_Error | Stop_Error;

`ifdef UART_RX_FIFO_DISCARD_ERR_EN
  logic       err_evt;
  logic [7:0] err_q, err_d;

  // Error frames bypass the FIFO entirely, so they can neither push nor overrun.
  assign err_evt = Parity_Error | Stop_Error;
  assign wr_req  = wr_evt & ~err_evt;

  // Saturating count of discarded error frames.
  always_comb begin
    err_d = err_q;
    if (err_evt && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  // Error counter register.
  always_ff @(posedge CLK) begin
    if (!RST) err_q <= '0;
    else      err_q <= err_d;
  end

  assign err_frames = err_q;
`else
  assign wr_req     = wr_evt;
  assign err_frames = '0;
`endif

  assign full     = (count_q == CNT_FULL);
  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid & rd_ready;
  // When the FIFO is full, a same-cycle pop makes room, so the write is still accepted.
  assign push     = wr_req & (~full | pop);
  assign drop     = wr_req & full & ~pop;

  // Next-state logic for the pointers, the occupancy counter and the sticky overrun flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (clr_ovr) ovr_d = 1'b0;
    if (drop)    ovr_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
    end
  end

  // Entry storage is not cleared on reset; the reset pointers make old entries unreachable.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= {Stop_Error, Parity_Error, P_DATA};
  end

  assign head       = mem[rd_ptr_q];
  assign rd_data    = rd_valid ? head[7:0] : '0;
`ifdef UART_RX_FIFO_DISCARD_ERR_EN
  assign rd_par_err = 1'b0;
  assign rd_stp_err = 1'b0;
`else
  assign rd_par_err = rd_valid & head[8];
  assign rd_stp_err = rd_valid & head[9];
`endif
  assign fifo_count = count_q;
  assign overrun    = ovr_q;

endmodule
